// File: rtl/tb_exit_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exit_monitor
//  Description : Simulation-side run monitor. Folds the global pass/fail
//                flags, per-hart exit strobes and a cycle watchdog into one
//                latched verdict, an exit value and a RUN cycle count.
//  Ports       : clk_i/rst_i          clock, synchronous active-high reset
//                start_i/clear_i      IDLE->RUN and DONE->IDLE pulses
//                max_cycles_i         watchdog limit (0 = disabled)
//                tests_passed_i/failed_i  global verdict flags
//                exit_valid_i/exit_value_i per-hart exit strobe and value
//                running_o/done_o     state decode
//                status_o             0 NONE,1 PASSED,2 FAILED,3 EXIT_OK,
//                                     4 EXIT_ERR,5 TIMEOUT
//                exit_value_o/exit_hart_o reported exit value and its hart
//                exited_mask_o        harts that exited this run
//                cycle_cnt_o          RUN cycles elapsed (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exit_monitor #(
    parameter int NUM_HARTS   = 1,
    parameter int VALUE_WIDTH = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int ALL_EXIT    = 0,
    localparam int HART_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             clear_i,
    input  logic [CNT_WIDTH-1:0]             max_cycles_i,
    input  logic                             tests_passed_i,
    input  logic                             tests_failed_i,
    input  logic [NUM_HARTS-1:0]             exit_valid_i,
    input  logic [NUM_HARTS*VALUE_WIDTH-1:0] exit_value_i,
    output logic                             running_o,
    output logic                             done_o,
    output logic [2:0]                       status_o,
    output logic [VALUE_WIDTH-1:0]           exit_value_o,
    output logic [HART_W-1:0]                exit_hart_o,
    output logic [NUM_HARTS-1:0]             exited_mask_o,
    output logic [CNT_WIDTH-1:0]             cycle_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] C_ST_NONE     = 3'd0;
    localparam logic [2:0] C_ST_PASSED   = 3'd1;
    localparam logic [2:0] C_ST_FAILED   = 3'd2;
    localparam logic [2:0] C_ST_EXIT_OK  = 3'd3;
    localparam logic [2:0] C_ST_EXIT_ERR = 3'd4;
    localparam logic [2:0] C_ST_TIMEOUT  = 3'd5;

    logic [1:0]             r_state;
    logic [CNT_WIDTH-1:0]   r_max;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [NUM_HARTS-1:0]   r_mask;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [HART_W-1:0]      r_hart;
    logic [2:0]             r_status;

    logic [NUM_HARTS-1:0]   w_new;
    logic [NUM_HARTS-1:0]   w_mask_next;
    logic                   w_lo_any;
    logic [HART_W-1:0]      w_lo_idx;
    logic [VALUE_WIDTH-1:0] w_lo_val;
    logic                   w_nz_any;
    logic [HART_W-1:0]      w_nz_idx;
    logic [VALUE_WIDTH-1:0] w_nz_val;
    logic [VALUE_WIDTH-1:0] w_val_next;
    logic [HART_W-1:0]      w_hart_next;
    logic                   w_exit_done;
    logic                   w_timeout;
    logic                   w_end;
    logic [2:0]             w_status_next;

    always_comb begin
        // Only first strobes from a hart count; repeats are masked off.
        w_new       = exit_valid_i & ~r_mask;
        w_mask_next = r_mask | w_new;
        w_lo_any    = 1'b0;
        w_lo_idx    = '0;
        w_lo_val    = '0;
        w_nz_any    = 1'b0;
        w_nz_idx    = '0;
        w_nz_val    = '0;
        // Descending scan so the lowest index is the last to win.
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (w_new[h]) begin
                w_lo_any = 1'b1;
                w_lo_idx = HART_W'(h);
                w_lo_val = exit_value_i[h*VALUE_WIDTH +: VALUE_WIDTH];
                if (exit_value_i[h*VALUE_WIDTH +: VALUE_WIDTH] != '0) begin
                    w_nz_any = 1'b1;
                    w_nz_idx = HART_W'(h);
                    w_nz_val = exit_value_i[h*VALUE_WIDTH +: VALUE_WIDTH];
                end
            end
        end

        w_val_next  = r_value;
        w_hart_next = r_hart;
        if (ALL_EXIT == 0) begin
            if ((r_mask == '0) && w_lo_any) begin
                w_val_next  = w_lo_val;
                w_hart_next = w_lo_idx;
            end
        end else begin
            // A nonzero captured value is sticky. Until one arrives, track
            // the most recent exiter so an all-zero run reports the last hart.
            if (r_value == '0) begin
                if (w_nz_any) begin
                    w_val_next  = w_nz_val;
                    w_hart_next = w_nz_idx;
                end else if (w_lo_any) begin
                    w_hart_next = w_lo_idx;
                end
            end
        end

        w_exit_done = (ALL_EXIT == 0) ? w_lo_any : (&w_mask_next);
        w_timeout   = (r_max != '0) && (r_cnt >= (r_max - CNT_WIDTH'(1)));

        w_end         = 1'b1;
        w_status_next = C_ST_NONE;
        if (tests_failed_i) begin
            w_status_next = C_ST_FAILED;
        end else if (tests_passed_i) begin
            w_status_next = C_ST_PASSED;
        end else if (w_exit_done) begin
            w_status_next = (w_val_next == '0) ? C_ST_EXIT_OK : C_ST_EXIT_ERR;
        end else if (w_timeout) begin
            w_status_next = C_ST_TIMEOUT;
        end else begin
            w_end = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_max    <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_value  <= '0;
            r_hart   <= '0;
            r_status <= C_ST_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state  <= S_RUN;
                        r_max    <= max_cycles_i;
                        r_cnt    <= '0;
                        r_mask   <= '0;
                        r_value  <= '0;
                        r_hart   <= '0;
                        r_status <= C_ST_NONE;
                    end
                end
                S_RUN: begin
                    r_mask  <= w_mask_next;
                    r_value <= w_val_next;
                    r_hart  <= w_hart_next;
                    if (!(&r_cnt)) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                    if (w_end) begin
                        r_state  <= S_DONE;
                        r_status <= w_status_next;
                    end
                end
                S_DONE: begin
                    if (clear_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign running_o     = (r_state == S_RUN);
    assign done_o        = (r_state == S_DONE);
    assign status_o      = r_status;
    assign exit_value_o  = r_value;
    assign exit_hart_o   = r_hart;
    assign exited_mask_o = r_mask;
    assign cycle_cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: doc/tb_exit_monitor.md
Name: tb_exit_monitor

Overview:
- Parametrised simulation-side run monitor that decides how a test run ends, for N harts/exit channels.
- Replaces the ad-hoc pass/fail/exit checks and the max-cycle abort in the verilator top level with one synthesizable, registered block.
- The bench top instantiates it between the core wrapper status outputs and the `$finish` logic.
- It combines the pass/fail flags, per-hart exit events and a cycle watchdog into a single latched verdict, an exit value and a cycle count.

Parameters:
- NUM_HARTS, 1, number of exit channels (1..32).
- VALUE_WIDTH, 32, width of each exit value.
- CNT_WIDTH, 32, cycle counter and max-cycle width.
- ALL_EXIT, 0, 0 = first exit ends the run; 1 = run ends only when every hart has exited.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  IDLE->RUN pulse; samples max_cycles_i.
- clear_i  in  1  DONE->IDLE pulse.
- max_cycles_i  in  CNT_WIDTH  watchdog limit; 0 = watchdog disabled.
- tests_passed_i  in  1  global pass flag.
- tests_failed_i  in  1  global fail flag.
- exit_valid_i  in  NUM_HARTS  per-hart exit strobe.
- exit_value_i  in  NUM_HARTS*VALUE_WIDTH  per-hart exit value; hart h occupies bits [h*VW +: VW].
- running_o  out  1  state == RUN.
- done_o  out  1  state == DONE.
- status_o  out  3  0 NONE, 1 PASSED, 2 FAILED, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT.
- exit_value_o  out  VALUE_WIDTH  reported exit value.
- exit_hart_o  out  $clog2(NUM_HARTS) (min 1)  hart whose value is reported.
- exited_mask_o  out  NUM_HARTS  harts that have exited this run.
- cycle_cnt_o  out  CNT_WIDTH  RUN cycles elapsed.

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE; all outputs 0. Reset overrides everything, including mid-RUN and DONE.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - All inputs except start_i are ignored.
  - start_i=1: go to RUN; max_q <= max_cycles_i; cycle_cnt, exited_mask, exit_value, exit_hart and status all cleared.
- RUN, counting:
  - cycle_cnt_o increments every RUN cycle, saturating at all-ones.
  - The first RUN cycle sees cycle_cnt_o == 0.
- RUN, per-hart exits:
  - Each exit_valid_i[h] with mask[h]==0 sets mask[h].
  - Repeat strobes from an already-exited hart are ignored; its first value is kept.
- RUN, exit-value capture:
  - ALL_EXIT=0: the lowest-index valid hart in the first exit cycle is captured.
  - ALL_EXIT=1: the first nonzero value in arrival order is captured; ties within a cycle go to the lowest index. If all values are 0, report value 0 with exit_hart = the last hart to exit, lowest index on a tie.
- RUN, end conditions, evaluated each cycle in priority order (first match wins, go to DONE next edge):
  1. tests_failed_i -> FAILED.
  2. tests_passed_i -> PASSED.
  3. Exit complete -> EXIT_OK if the captured value is 0, else EXIT_ERR. Exit is complete when any new exit occurs (ALL_EXIT=0), or when the mask including this cycle's exits is all ones (ALL_EXIT=1).
  4. max_q != 0 and cycle_cnt_o >= max_q-1 -> TIMEOUT. With max 5 the run times out after exactly 5 RUN cycles and cycle_cnt_o freezes at 5.
- Transition into DONE:
  - Exits, mask updates and the counter increment of the ending cycle are all committed.
  - For FAILED/PASSED/TIMEOUT, exit_value_o and exit_hart_o show whatever was captured so far (possibly 0).
- Latency: a condition seen at edge k gives done_o=1 and a valid status_o from edge k+1.
- DONE:
  - All outputs are frozen; inputs are ignored except clear_i and rst_i.
  - clear_i -> IDLE, with outputs held until the next start_i.
  - start_i is ignored in DONE and in RUN.
- Simultaneous start_i and clear_i in IDLE: start wins. In DONE: clear wins, and start_i is ignored.
- NUM_HARTS=1: exit_hart_o is 1 bit, tied 0.

Test Plan:
1. Reset, start, max 0, tests_passed_i at RUN cycle 3 -> done_o at the next edge, status 1, cycle_cnt_o=4, exit_value_o=0.
2. NUM_HARTS=4, ALL_EXIT=0: harts 2 and 1 strobe in the same cycle with values 7 and 0 -> exit_hart_o=1, value 0, status 3, mask 4'b0110.
3. ALL_EXIT=1: harts exit on separate cycles (0:0, 3:9, 1:5, 2:0) -> DONE only after hart 2; status 4, value 9, hart 3, mask 4'hF. Then strobe hart 3 again mid-run in a rerun -> value unchanged.
4. max 5, no events -> status 5 after 5 RUN cycles, cycle_cnt_o=5. Then tests_failed_i and the timeout condition in the same cycle -> status 2.
5. Drive rst_i mid-RUN and again in DONE -> all outputs 0, IDLE. clear_i in DONE -> IDLE with outputs held; start_i -> cleared and counting.
6. Counter saturation with CNT_WIDTH=4, max 0: run 20 cycles -> cycle_cnt_o holds 4'hF, no timeout.
